axi_req_master: RTL
===================

AXI_REQ_MASTER -- requirements
Module: axi_req_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024; cycles without AXI completion before abort (used only with AXI_REQ_MASTER_TIMEOUT_EN).
REQ-002 clk_i  input  1  single clock; all logic on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  initiator request valid.
REQ-005 req_ready  output  1  block can accept a request.
REQ-006 req_wr  input  1  1=write, 0=read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_wstrb  input  4  write byte strobes.
REQ-010 rsp_valid  output  1  one-cycle response pulse, no backpressure.
REQ-011 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-012 rsp_err  output  1  error flag, valid with rsp_valid.
REQ-013 m_axi_awvalid/awready/awaddr[31:0], m_axi_wvalid/wready/wdata[31:0]/wstrb[3:0], m_axi_bvalid/bready/bresp[1:0]  AXI write channels, master side.
REQ-014 m_axi_arvalid/arready/araddr[31:0], m_axi_rvalid/rready/rdata[31:0]/rresp[1:0]/rlast  AXI read channels, master side; single-beat only.

Function
REQ-015 States: IDLE, AR, R, AW_W, B, RSP; req_ready SHALL be 1 only in IDLE.
REQ-016 On req_valid && req_ready (cycle N), addr/wdata/wstrb/wr SHALL be registered; read -> AR, write -> AW_W at N+1.
REQ-017 AR: arvalid=1, araddr stable until arvalid && arready; then R with rready=1.
REQ-018 R: on rvalid && rready capture rdata, rsp_err = (rresp != OKAY); go RSP; rlast ignored.
REQ-019 AW_W: awvalid and wvalid both asserted at N+1; each SHALL drop independently after its own handshake; simultaneous or either-order handshakes SHALL both be accepted; enter B only after both done.
REQ-020 B: bready=1; on bvalid capture rsp_err = (bresp != OKAY), rsp_rdata = 0; go RSP.
REQ-021 RSP: rsp_valid=1 for exactly one cycle, then IDLE; minimum read latency req-accept N to rsp_valid = N+3 (arready at N+1, rvalid at N+2).
REQ-022 No valid SHALL depend combinationally on any ready; all AXI outputs registered.
REQ-023 At most one outstanding transaction; AxID/LEN/SIZE/BURST not driven (single 32-bit beat).

Reset
REQ-024 On rst_ni=0 SHALL immediately force: state IDLE, all m_axi_*valid=0, bready=rready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0 while asserted, 1 in first cycle after release.
REQ-025 Reset mid-transaction SHALL abandon it without any rsp_valid.

Configuration
REQ-026 Macro AXI_REQ_MASTER_TIMEOUT_EN defined: counter cleared on leaving IDLE, increments each cycle in AR/R/AW_W/B; on reaching TIMEOUT_CYCLES all AXI valids/readies drop, go RSP with rsp_err=1, rsp_rdata=0.
REQ-027 Macro undefined: no counter, block waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-028 Package axi_pkg SHALL hold state enum axi_mst_state_t and resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
REQ-029 Timeout counter SHALL be sub-module axi_wdog_ctr (clear, enable, expired), instantiated only under AXI_REQ_MASTER_TIMEOUT_EN.

Verification
REQ-030 Read 0xF800_0004, arready at N+1, rvalid at N+2 rdata=0x0000_00A5 OKAY -> rsp_valid at N+3, rsp_rdata=0xA5, rsp_err=0.
REQ-031 Write 0xF800_0000 data 0x41 wstrb 0xF, wready 3 cycles before awready -> awaddr/wdata held until each handshake, single rsp_valid after bvalid, rsp_err=0.
REQ-032 Read with rresp=SLVERR -> rsp_err=1; write with bresp=DECERR -> rsp_err=1.
REQ-033 arready held low 5 cycles -> arvalid stays 1, araddr stable, req_ready 0, no rsp_valid until completion.
REQ-034 rst_ni pulsed low during B -> bready and rsp_valid 0 same cycle, no response; req_ready=1 after release.
REQ-035 With AXI_REQ_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, rvalid never -> rsp_valid with rsp_err=1 exactly 16 cycles after entering AR, rready=0 afterwards.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types for the single-beat AXI request master: FSM state encoding and AXI response codes.
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW_W,
    ST_B,
    ST_RSP
  } axi_mst_state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axi_wdog_ctr.sv
// Watchdog counter: counts enabled cycles since clear, flags expiry on the LIMIT-th enabled cycle.
// Latency: expired is combinational from the count register; clear and enable take effect next cycle.
module axi_wdog_ctr #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT) + 1;

  logic [W-1:0] cnt;

  // Expiry is asserted while the LIMIT-th enabled cycle is in progress, so the owner reacts on that edge.
  assign expired = enable && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/axi_req_master.sv
// Converts simple one-at-a-time requests into single-beat AXI4 transactions; response pulse >= 3 cycles after accept.
// No backpressure on responses; all AXI outputs registered. Optional abort timer under AXI_REQ_MASTER_TIMEOUT_EN.
module axi_req_master
  import axi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast
);

  axi_mst_state_t state;
  logic           busy;
  logic           tmo_expired;
  logic           unused_rlast;

  assign busy         = (state == ST_AR) || (state == ST_R) || (state == ST_AW_W) || (state == ST_B);
  assign req_ready    = rst_ni && (state == ST_IDLE);
  assign unused_rlast = m_axi_rlast;

`ifdef AXI_REQ_MASTER_TIMEOUT_EN
  axi_wdog_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear   (state == ST_IDLE),
    .enable  (busy),
    .expired (tmo_expired)
  );
`else
  logic [31:0] unused_tmo;
  assign unused_tmo  = TIMEOUT_CYCLES;
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= ST_IDLE;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_rready  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_wr) begin
              m_axi_awvalid <= 1'b1;
              m_axi_awaddr  <= req_addr;
              m_axi_wvalid  <= 1'b1;
              m_axi_wdata   <= req_wdata;
              m_axi_wstrb   <= req_wstrb;
              state         <= ST_AW_W;
            end else begin
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= req_addr;
              state         <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_R;
          end
        end
        ST_R: begin
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_err      <= (m_axi_rresp != OKAY);
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
          end
        end
        ST_AW_W: begin
          // A channel whose valid is already low finished its handshake in an earlier cycle.
          if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= ST_B;
          end
        end
        ST_B: begin
          if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bready <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= (m_axi_bresp != OKAY);
            rsp_valid    <= 1'b1;
            state        <= ST_RSP;
          end
        end
        ST_RSP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      // Abort overrides whatever the channel logic decided this cycle.
      if (busy && tmo_expired) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_rdata     <= '0;
        rsp_err       <= 1'b1;
        rsp_valid     <= 1'b1;
        state         <= ST_RSP;
      end
    end
  end

endmodule
